alu_cmd_sequencer: RTL

- Initiator for the combinational ALU: accepts commands over a valid/ready interface and owns a 32-bit accumulator.
- Drives alu_a/alu_b/alu_op, then writes alu_res back into the accumulator, one ALU operation per cycle for a programmable repeat count.
- Returns the final accumulator value over a valid/ready response interface.
- Sits between the lab FSM/top-level controller and the ALU instance.

---
 rtl/alu_cmd_sequencer_pkg.sv | 20 ++
 rtl/alu_cmd_sequencer.sv | 96 +++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared ALU op encoding and sequencer state encoding used by the
// command sequencer and its neighbours in the parent.
package alu_cmd_sequencer_pkg;

  localparam logic [4:0] A_NOP    = 5'h00;
  localparam logic [4:0] A_ADD    = 5'h01;
  localparam logic [4:0] A_SUB    = 5'h02;
  localparam logic [4:0] A_AND    = 5'h03;
  localparam logic [4:0] A_OR     = 5'h04;
  localparam logic [4:0] A_XOR    = 5'h05;
  localparam logic [4:0] A_NOR    = 5'h06;
  localparam logic [4:0] A_MAX_OP = A_NOR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer: owns the accumulator and repeatedly issues acc = acc op data
// to an external combinational ALU, then returns the result over valid/ready.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 8,
  parameter int ISSUE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [4:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_cnt,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy,
  output logic [ISSUE_W-1:0] issue_count
);

  seq_state_t        state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] operand;
  logic [4:0]        op;
  logic [CNT_W-1:0]  remaining;
  logic              err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      operand     <= '0;
      op          <= A_NOP;
      remaining   <= '0;
      err         <= 1'b0;
      issue_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op        <= cmd_op;
            operand   <= cmd_data;
            remaining <= cmd_cnt;
            if (cmd_load) begin
              acc   <= cmd_data;
              err   <= 1'b0;
              state <= DONE;
            end else if (cmd_op > A_MAX_OP) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (cmd_cnt == '0) begin
              err   <= 1'b0;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          acc         <= alu_res;
          remaining   <= remaining - 1'b1;
          issue_count <= issue_count + 1'b1;
          if (remaining == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they follow an async reset immediately
  // and the ALU sees A_NOP with zero operands whenever nothing is being issued.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign alu_a     = (state == ISSUE) ? acc     : '0;
  assign alu_b     = (state == ISSUE) ? operand : '0;
  assign alu_op    = (state == ISSUE) ? op      : A_NOP;
  assign rsp_valid = (state == DONE);
  assign rsp_data  = (state == DONE) ? acc : '0;
  assign rsp_zero  = (state == DONE) && (acc == '0);
  assign rsp_err   = (state == DONE) && err;

endmodule
